// File: rtl/axi_lite_master_param.sv
// Single-outstanding AXI4-Lite master: a start/done command port drives the five AXI channels.
// Widths are parameters; a per-state watchdog turns a silent slave into a 2'b10 completion.
//
// state     | meaning
// S_IDLE    | waiting for AXI_Start
// S_WR      | AW and W offered together, each retired on its own handshake
// S_WR_RESP | BREADY high, waiting for BVALID
// S_RD_ADDR | ARVALID high, waiting for ARREADY
// S_RD_DATA | RREADY high, waiting for RVALID
module axi_lite_master_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AXI_Start,
    input  logic                  AXI_WriteEn,
    input  logic [ADDR_W-1:0]     AXI_Addr,
    input  logic [DATA_W-1:0]     AXI_WData,
    input  logic [DATA_W/8-1:0]   AXI_WStrb,
    output logic [DATA_W-1:0]     AXI_RData,
    output logic [1:0]            AXI_Resp,
    output logic                  AXI_Done,
    output logic                  AXI_Busy,
    output logic                  AXI_Timeout,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0] RESP_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          resp_q, resp_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic                done_q, done_d, busy_q, busy_d, timeout_q, timeout_d;
    logic                expired, aw_sent, w_sent, abort;

    assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    // A channel counts as sent once its VALID has dropped or it handshakes this cycle.
    assign aw_sent = !awvalid_q || M_AXI_AWREADY;
    assign w_sent  = !wvalid_q || M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (AXI_Start) begin
                    addr_d  = AXI_Addr;
                    wdata_d = AXI_WData;
                    wstrb_d = AXI_WStrb;
                    if (AXI_WriteEn) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (aw_sent && w_sent) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d   = M_AXI_BRESP;
                    done_d   = 1'b1;
                    bready_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d  = M_AXI_RDATA;
                    resp_d   = M_AXI_RRESP;
                    done_d   = 1'b1;
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            resp_d    = RESP_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
        end
        busy_d = (state_d != S_IDLE);
        // Watchdog restarts on every state entry and idles at zero.
        cnt_d  = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign AXI_RData     = rdata_q;
    assign AXI_Resp      = resp_q;
    assign AXI_Done      = done_q;
    assign AXI_Busy      = busy_q;
    assign AXI_Timeout   = timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_lite_master_param.sv
// Bench for axi_lite_master_param (64-bit data, 8-cycle watchdog): per-transaction slave delays,
// expected waveform derived from channel delays by plain cycle arithmetic.
module tb_axi_lite_master_param;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;
    localparam int TMO    = 8;
    localparam int NEVER  = 99;

    logic clk = 1'b0;
    logic rst;
    logic AXI_Start, AXI_WriteEn;
    logic [ADDR_W-1:0] AXI_Addr;
    logic [DATA_W-1:0] AXI_WData, AXI_RData;
    logic [STRB_W-1:0] AXI_WStrb;
    logic [1:0] AXI_Resp;
    logic AXI_Done, AXI_Busy, AXI_Timeout;
    logic [ADDR_W-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [DATA_W-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [STRB_W-1:0] M_AXI_WSTRB;
    logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
    logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi_lite_master_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst),
        .AXI_Start(AXI_Start), .AXI_WriteEn(AXI_WriteEn), .AXI_Addr(AXI_Addr),
        .AXI_WData(AXI_WData), .AXI_WStrb(AXI_WStrb), .AXI_RData(AXI_RData),
        .AXI_Resp(AXI_Resp), .AXI_Done(AXI_Done), .AXI_Busy(AXI_Busy), .AXI_Timeout(AXI_Timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        int                d1a;   // AWREADY / ARREADY delay after VALID rise
        int                d1b;   // WREADY delay after WVALID rise (writes)
        int                d2;    // BVALID / RVALID delay after READY rise
        logic [1:0]        resp;
        logic [DATA_W-1:0] rdata;
        bit                hold;  // keep Start high with junk fields while busy
    } txn_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ctl_vec();
        return {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                AXI_Busy, AXI_Done, AXI_Timeout};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic txn_t mk(input bit we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] wstrb,
                                input int d1a, input int d1b, input int d2,
                                input logic [1:0] resp, input logic [DATA_W-1:0] rdata,
                                input bit hold);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
        t.d1a = d1a; t.d1b = d1b; t.d2 = d2; t.resp = resp; t.rdata = rdata; t.hold = hold;
        return t;
    endfunction

    function automatic int rand_dly();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 10) return int'($urandom_range(0, 3));
        if (r < 12) return TMO - 1;
        if (r < 14) return TMO;
        return NEVER;
    endfunction

    task automatic clear_slave();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            AXI_Start = 1'b0;
            chk("idle_ctl", ctl_vec(), 8'h00);
            chk("idle_resp", AXI_Resp, m_resp);
        end
    endtask

    // Called at the negedge of cycle 0 (Start cycle); returns at the negedge of the Done cycle.
    task automatic run_txn(input txn_t t);
        int  dmax, len1, len2, p2, d;
        bit  to1, to2, tmo, awv, wv, brd, arv, rrd;
        dmax = (t.we && t.d1b > t.d1a) ? t.d1b : t.d1a;
        to1  = dmax >= TMO;
        len1 = to1 ? TMO : dmax + 1;
        p2   = 1 + len1;
        to2  = !to1 && (t.d2 >= TMO);
        len2 = to1 ? 0 : (to2 ? TMO : t.d2 + 1);
        d    = p2 + len2;
        tmo  = to1 || to2;
        AXI_Start = 1'b1; AXI_WriteEn = t.we; AXI_Addr = t.addr;
        AXI_WData = t.wdata; AXI_WStrb = t.wstrb;
        for (int c = 1; c <= d; c++) begin
            @(negedge clk);
            AXI_Start = t.hold && (c < d);
            if (t.hold) begin
                AXI_WriteEn = 1'($urandom); AXI_Addr = $urandom;
                AXI_WData = {$urandom, $urandom}; AXI_WStrb = STRB_W'($urandom);
            end
            M_AXI_AWREADY = t.we && (c < d) && (c == 1 + t.d1a);
            M_AXI_WREADY  = t.we && (c < d) && (c == 1 + t.d1b);
            M_AXI_BVALID  = t.we && !to1 && (c < d) && (c == p2 + t.d2);
            M_AXI_BRESP   = t.resp;
            M_AXI_ARREADY = !t.we && (c < d) && (c == 1 + t.d1a);
            M_AXI_RVALID  = !t.we && !to1 && (c < d) && (c == p2 + t.d2);
            M_AXI_RDATA   = t.rdata;
            M_AXI_RRESP   = t.resp;
            awv = t.we && (c <= 1 + imin(t.d1a, len1 - 1));
            wv  = t.we && (c <= 1 + imin(t.d1b, len1 - 1));
            brd = t.we && !to1 && (c >= p2) && (c < d);
            arv = !t.we && (c < p2);
            rrd = !t.we && !to1 && (c >= p2) && (c < d);
            if (c == d) begin
                m_resp = tmo ? 2'b10 : t.resp;
                if (!t.we && !tmo) m_rdata = t.rdata;
            end
            chk($sformatf("ctl c%0d", c), ctl_vec(),
                {awv, wv, brd, arv, rrd, 1'(c < d), 1'(c == d), 1'((c == d) && tmo)});
            chk($sformatf("resp c%0d", c), AXI_Resp, m_resp);
            chk($sformatf("rdata c%0d", c), AXI_RData, m_rdata);
            if (awv) chk("awaddr", M_AXI_AWADDR, t.addr);
            if (arv) chk("araddr", M_AXI_ARADDR, t.addr);
            if (wv) begin
                chk("wdata", M_AXI_WDATA, t.wdata);
                chk("wstrb", M_AXI_WSTRB, t.wstrb);
            end
        end
    endtask

    task automatic reset_in_wr_resp();
        AXI_Start = 1'b1; AXI_WriteEn = 1'b1; AXI_Addr = 32'h80;
        AXI_WData = 64'hA5A5_5A5A_0F0F_F0F0; AXI_WStrb = 8'hFF;
        @(negedge clk);
        AXI_Start = 1'b0; M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        chk("rst_wr", ctl_vec(), 8'b1100_0100);
        @(negedge clk);
        clear_slave();
        chk("rst_wrresp", ctl_vec(), 8'b0010_0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_resp = 2'b00; m_rdata = '0;
        chk("rst_ctl", ctl_vec(), 8'h00);
        chk("rst_resp", AXI_Resp, 2'b00);
        chk("rst_rdata", AXI_RData, 64'h0);
        chk("rst_awaddr", M_AXI_AWADDR, 32'h0);
        chk("rst_araddr", M_AXI_ARADDR, 32'h0);
        chk("rst_wdata", M_AXI_WDATA, 64'h0);
        chk("rst_wstrb", M_AXI_WSTRB, 8'h0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation ran past time limit, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        txn_t t;
        rst = 1'b1;
        AXI_Start = 1'b0; AXI_WriteEn = 1'b0; AXI_Addr = '0; AXI_WData = '0; AXI_WStrb = '0;
        clear_slave();
        M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
        m_rdata = '0; m_resp = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_ctl", ctl_vec(), 8'h00);
        chk("reset_rdata", AXI_RData, 64'h0);
        chk("reset_resp", AXI_Resp, 2'b00);
        chk("reset_awaddr", M_AXI_AWADDR, 32'h0);
        chk("reset_wstrb", M_AXI_WSTRB, 8'h0);
        rst = 1'b0;
        idle(2);

        run_txn(mk(1, 32'h40, 64'hDEADBEEF, 8'h0F, 0, 0, 0, 2'b00, 64'h0, 0));
        idle(2);
        run_txn(mk(1, 32'h40, 64'hDEADBEEF, 8'h0F, 4, 0, 0, 2'b00, 64'h0, 0));
        idle(2);
        run_txn(mk(0, 32'h10, 64'h0, 8'h0, 0, 0, 2, 2'b10, 64'h12345678, 0));
        idle(2);
        run_txn(mk(0, 32'h20, 64'h0, 8'h0, NEVER, 0, 0, 2'b00, 64'hFFFF, 0));
        idle(2);
        run_txn(mk(0, 32'h24, 64'h0, 8'h0, TMO - 1, 0, TMO - 1, 2'b01, 64'hCAFE_0000_BEEF, 0));
        idle(1);
        run_txn(mk(1, 32'h30, 64'h1122_3344_5566_7788, 8'hA5, 1, NEVER, 0, 2'b00, 64'h0, 0));
        idle(1);
        run_txn(mk(1, 32'h34, 64'h99, 8'h81, TMO - 1, 2, NEVER, 2'b00, 64'h0, 0));
        idle(1);
        run_txn(mk(1, 32'h38, 64'h77, 8'h3C, 0, TMO - 1, 0, 2'b11, 64'h0, 0));
        idle(1);

        for (int i = 0; i < 6; i++)
            run_txn(mk(((i % 2) == 0), $urandom, {$urandom, $urandom}, 8'($urandom),
                       0, 0, 0, 2'($urandom), {$urandom, $urandom}, 1));
        idle(2);

        reset_in_wr_resp();
        run_txn(mk(0, 32'h44, 64'h0, 8'h0, 1, 0, 1, 2'b00, 64'h0123_4567_89AB_CDEF, 0));
        idle(1);

        for (int i = 0; i < 200; i++) begin
            t = mk(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                   rand_dly(), rand_dly(), rand_dly(), 2'($urandom), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0));
            run_txn(t);
            idle(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_master_param.md
# axi_lite_master_param

Parametrised AXI4-Lite single-outstanding master bridging a simple start/done command port onto the five AXI4-Lite channels. It is the successor of the fixed-32-bit master: address and data widths are configurable, byte strobes are user-supplied, AW and W are issued concurrently with independent handshakes, and the slave response code is reported back. A per-transaction watchdog prevents a silent slave from hanging the requester. It sits between local control logic (register sequencers, DMA descriptors fetchers) and the AXI4-Lite interconnect.

## Interface
- ADDR_W, 32, address width (bits), ≥12
- DATA_W, 32, data width; 32 or 64 only
- TIMEOUT, 256, max cycles waited in any one channel state; 0 disables watchdog
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- AXI_Start  input  1  request; accepted only when AXI_Busy=0
- AXI_WriteEn  input  1  1=write, 0=read; sampled with AXI_Start
- AXI_Addr  input  ADDR_W  transaction address; sampled with AXI_Start
- AXI_WData  input  DATA_W  write data; sampled with AXI_Start
- AXI_WStrb  input  DATA_W/8  write byte strobes; sampled with AXI_Start
- AXI_RData  output  DATA_W  last read data
- AXI_Resp  output  2  response of last completed transaction (BRESP/RRESP, or 2'b10 on timeout)
- AXI_Done  output  1  one-cycle completion pulse
- AXI_Busy  output  1  transaction in progress
- AXI_Timeout  output  1  one-cycle pulse coincident with AXI_Done when watchdog fired
- M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions; ADDR widths ADDR_W, DATA widths DATA_W, WSTRB DATA_W/8, RESP 2

## Operation
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA.
- IDLE: AXI_Start=1 latches addr/data/strb into registers; goes to WR if AXI_WriteEn else RD_ADDR. Start while Busy=1 is ignored (no queueing).
- WR: AWVALID and WVALID both asserted on entry; each deasserts the cycle after its own VALID&READY; two "sent" flags track completion. When both sent (same cycle allowed) → WR_RESP. AWADDR/WDATA/WSTRB stable while respective VALID high.
- WR_RESP: BREADY=1; on BVALID: AXI_Resp<=BRESP, Done pulse, → IDLE.
- RD_ADDR: ARVALID=1 until ARREADY; → RD_DATA.
- RD_DATA: RREADY=1; on RVALID: AXI_RData<=RDATA, AXI_Resp<=RRESP, Done pulse, → IDLE.
- AXI_RData changes only on a read completion; writes and timeouts leave it unchanged.
- Watchdog: counter clears on every state entry; increments each cycle in a non-IDLE state; when count reaches TIMEOUT-1 without the state's exit handshake: all VALID/READY deassert next cycle, AXI_Resp<=2'b10, AXI_Done and AXI_Timeout pulse, → IDLE. Handshake in the same cycle as expiry wins (normal completion).
- Non-OKAY responses are reported, not retried.

## Timing
- Reset values: all VALID/READY 0, AWADDR/ARADDR/WDATA 0, WSTRB 0, AXI_RData 0, AXI_Resp 0, Done/Busy/Timeout 0, state IDLE. Reset mid-transaction aborts immediately, no Done.
- All outputs registered.
- Start accepted at cycle 0 → VALIDs high cycle 1, Busy high cycle 1.
- Always-ready slave: write AW/W handshake cycle 1, BREADY cycle 2, BVALID cycle 2 → Done cycle 3. Read identical: ARVALID 1, RREADY 2, Done 3.
- Done cycle: state IDLE, Busy=0; a Start in the Done cycle is accepted (back-to-back every 3 cycles).
- AWREADY at cycle k and WREADY at cycle m: BREADY from max(k,m)+1.

## Test plan
- Write, always-ready slave, Addr=0x40, WData=0xDEADBEEF, WStrb=0xF, BRESP=0 -> AWVALID/WVALID cycle 1 only, Done cycle 3, Resp=0, RData unchanged.
- Write, AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops cycle 2, AWVALID held with stable 0x40 until cycle 5, BREADY cycle 6.
- Read Addr=0x10, RVALID after 2 cycles with RDATA=0x12345678, RRESP=2'b10 -> AXI_RData=0x12345678, Resp=2'b10, Done one cycle.
- TIMEOUT=8, slave never asserts ARREADY -> ARVALID drops, Done+Timeout pulse 8 cycles after ARVALID rise, Resp=2'b10, RData unchanged.
- Start held high continuously with alternating write/read -> transaction every 3 cycles, Starts during Busy ignored; DATA_W=64 run checks WSTRB=8 bits.
- rst asserted in WR_RESP -> next cycle all outputs at reset values, no Done; next Start works normally.
